ram_byte_streamer: RTL and testbench

// - Read-side master for the 128x32 word RAM: fetches a run of 32-bit words via the RAM's
//   en/action port and streams them out as bytes over a valid/ready handshake (UART TX path).
// - Sits between the RAM and the UART transmitter; ships stored AES blocks back over RS-232.

---
 rtl/ram_byte_streamer.sv | 171 +++++++++++++++++
 tb/tb_ram_byte_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_byte_streamer.sv
// Reads a run of 32-bit RAM words and streams them MSB-first as bytes over valid/ready.
// Optional trailing XOR checksum byte when RAM_STREAM_CHECKSUM_EN is defined.
module ram_byte_streamer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        word_count,
    output logic              ram_en,
    output logic              ram_action,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

`ifdef RAM_STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, CKSUM, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, FIN} state_t;
`endif

    state_t            state, n_state;
    logic              n_en, n_valid, n_busy, n_done;
    logic [ADDR_W-1:0] n_addr;
    logic [7:0]        n_txd;
    logic [31:0]       shreg, n_shreg;
    logic [1:0]        bcnt, n_bcnt;
    logic [7:0]        words, n_words;
    logic              hs;

`ifdef RAM_STREAM_CHECKSUM_EN
    logic [7:0] xsum, n_xsum;
`endif

    assign ram_action = 1'b0;
    assign hs = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            bcnt     <= '0;
            words    <= '0;
`ifdef RAM_STREAM_CHECKSUM_EN
            xsum     <= '0;
`endif
        end else begin
            state    <= n_state;
            ram_en   <= n_en;
            ram_addr <= n_addr;
            tx_data  <= n_txd;
            tx_valid <= n_valid;
            busy     <= n_busy;
            done     <= n_done;
            shreg    <= n_shreg;
            bcnt     <= n_bcnt;
            words    <= n_words;
`ifdef RAM_STREAM_CHECKSUM_EN
            xsum     <= n_xsum;
`endif
        end
    end

    always_comb begin
        n_state = state;
        n_en    = ram_en;
        n_addr  = ram_addr;
        n_txd   = tx_data;
        n_valid = tx_valid;
        n_busy  = busy;
        n_done  = 1'b0;
        n_shreg = shreg;
        n_bcnt  = bcnt;
        n_words = words;
`ifdef RAM_STREAM_CHECKSUM_EN
        n_xsum  = xsum;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef RAM_STREAM_CHECKSUM_EN
                    n_xsum = '0;
`endif
                    if (word_count != 8'd0) begin
                        n_words = word_count;
                        n_addr  = base_addr;
                        n_en    = 1'b1;
                        n_busy  = 1'b1;
                        n_state = RD;
                    end else begin
                        n_done  = 1'b1;
                        n_state = FIN;
                    end
                end
            end
            RD: begin
                n_en    = 1'b0;
                n_state = CAP;
            end
            CAP: begin
                n_shreg = ram_rdata[31:0];
                n_txd   = ram_rdata[31:24];
                n_valid = 1'b1;
                n_bcnt  = '0;
                n_state = SEND;
            end
            SEND: begin
                if (hs) begin
`ifdef RAM_STREAM_CHECKSUM_EN
                    n_xsum = xsum ^ tx_data;
`endif
                    if (bcnt == 2'd3) begin
                        n_valid = 1'b0;
                        n_words = words - 8'd1;
                        if (words != 8'd1) begin
                            n_addr  = ram_addr + 1'b1;
                            n_en    = 1'b1;
                            n_state = RD;
                        end else begin
`ifdef RAM_STREAM_CHECKSUM_EN
                            n_state = CKSUM;
`else
                            n_done  = 1'b1;
                            n_busy  = 1'b0;
                            n_state = FIN;
`endif
                        end
                    end else begin
                        n_bcnt  = bcnt + 2'd1;
                        n_shreg = {shreg[23:0], 8'h00};
                        n_txd   = shreg[23:16];
                    end
                end
            end
`ifdef RAM_STREAM_CHECKSUM_EN
            CKSUM: begin
                // first cycle presents the accumulated XOR, then waits for handshake
                if (!tx_valid) begin
                    n_valid = 1'b1;
                    n_txd   = xsum;
                end else if (tx_ready) begin
                    n_valid = 1'b0;
                    n_done  = 1'b1;
                    n_busy  = 1'b0;
                    n_state = FIN;
                end
            end
`endif
            FIN: begin
                n_state = IDLE;
            end
            default: begin
                n_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_byte_streamer.sv
// Self-checking bench for ram_byte_streamer: RAM model, expected byte stream from memory image.
// Define RAM_STREAM_CHECKSUM_EN to expect the trailing XOR byte.
module tb_ram_byte_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  base_addr;
    logic [7:0]  word_count;
    logic        ram_en;
    logic        ram_action;
    logic [6:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    ram_byte_streamer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .ram_en(ram_en), .ram_action(ram_action),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    always @(posedge clk) if (ram_en && !ram_action) ram_rdata <= mem[ram_addr];

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         addr_q[$];
    int first_valid, done_cyc, done_hi, busy_bad, stab_bad, act_bad;
    int byte_err, addr_err;
    bit timed_out;

`ifdef RAM_STREAM_CHECKSUM_EN
    localparam int BASIC_DONE = 9;
`else
    localparam int BASIC_DONE = 7;
`endif

    task automatic build_exp(input logic [6:0] b, input logic [7:0] c);
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        x = 8'h00;
        for (int i = 0; i < int'(c); i++) begin
            w = mem[(int'(b) + i) % 128];
            for (int k = 3; k >= 0; k--) begin
                exp_q.push_back(w[8*k +: 8]);
                x ^= w[8*k +: 8];
            end
        end
`ifdef RAM_STREAM_CHECKSUM_EN
        if (c != 8'd0) exp_q.push_back(x);
`endif
    endtask

    // Drives one transfer and records what the DUT did; tests judge the records.
    task automatic run(input logic [6:0] b, input logic [7:0] c,
                       input int glitch, input int rpct, input int hold0);
        bit         prev_stall;
        logic [7:0] prev_data;
        int         budget;
        build_exp(b, c);
        obs_q.delete();
        addr_q.delete();
        first_valid = -1; done_cyc = -1; done_hi = 0;
        busy_bad = 0; stab_bad = 0; act_bad = 0; timed_out = 0;
        prev_stall = 0; prev_data = 8'h00;
        @(posedge clk); #1;
        base_addr = b; word_count = c; start = 1'b1;
        tx_ready = (hold0 > 0) ? 1'b0 : ($urandom_range(99) < rpct);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 7'($urandom);
        word_count = 8'($urandom);
        budget = 200 + int'(c) * 100;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (ram_action !== 1'b0) act_bad++;
            if (ram_en === 1'b1) addr_q.push_back(int'(ram_addr));
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stab_bad++;
            if (tx_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (tx_valid === 1'b1 && tx_ready) obs_q.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data = tx_data;
            if (done === 1'b1) begin
                done_hi++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 ? (busy !== (c != 8'd0)) : (busy !== 1'b0)) busy_bad++;
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
            @(posedge clk); #1;
            tx_ready = (cyc + 1 <= hold0) ? 1'b0 : ($urandom_range(99) < rpct);
            start = (cyc == glitch);
        end
        start = 1'b0;
        tx_ready = 1'b0;
        if (done_cyc < 0) timed_out = 1;
        byte_err = (obs_q.size() == exp_q.size()) ? 0 : 1000;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) byte_err++;
        addr_err = (addr_q.size() == int'(c)) ? 0 : 1000;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != (int'(b) + i) % 128) addr_err++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({ram_en, ram_action, ram_addr, tx_data, tx_valid, busy, done} !== 20'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {ram_en, ram_action, ram_addr, tx_data, tx_valid, busy, done});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem[7'h10] = 32'h11223344;
        run(7'h10, 8'd1, 0, 100, 0);
        n_total++;
        if (addr_q.size() != 1 || addr_q[0] != 'h10)
            $display("FAIL basic_addr: got %0d reads first %h want 1 read at 10",
                     addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1);
        else n_pass++;
        n_total++;
        if (byte_err != 0 || obs_q[0] !== 8'h11 || obs_q[3] !== 8'h44)
            $display("FAIL basic_bytes: err %0d want 0", byte_err);
        else n_pass++;
        n_total++;
        if (first_valid != 3) $display("FAIL basic_latency: got %0d want 3", first_valid);
        else n_pass++;
        n_total++;
        if (done_cyc != BASIC_DONE || done_hi != 1)
            $display("FAIL basic_done: cyc %0d hi %0d want %0d 1", done_cyc, done_hi, BASIC_DONE);
        else n_pass++;
        n_total++;
        if (busy_bad != 0 || act_bad != 0)
            $display("FAIL basic_busy: got %0d/%0d want 0", busy_bad, act_bad);
        else n_pass++;
    endtask

    task automatic test_wrap();
        mem[7'h7F] = 32'hA0A1A2A3;
        mem[7'h00] = 32'hB0B1B2B3;
        run(7'h7F, 8'd2, 0, 100, 0);
        n_total++;
        if (addr_q.size() != 2 || addr_q[0] != 'h7F || addr_q[1] != 0)
            $display("FAIL wrap_addr: got %0d reads err %0d want 7f,00", addr_q.size(), addr_err);
        else n_pass++;
        n_total++;
        if (byte_err != 0 || obs_q[4] !== 8'hB0)
            $display("FAIL wrap_bytes: err %0d want 0", byte_err);
        else n_pass++;
    endtask

    task automatic test_stall();
        mem[7'h22] = $urandom;
        run(7'h22, 8'd1, 0, 100, 7);
        n_total++;
        if (stab_bad != 0 || first_valid != 3)
            $display("FAIL stall_hold: unstable %0d first %0d want 0 3", stab_bad, first_valid);
        else n_pass++;
        n_total++;
        if (byte_err != 0) $display("FAIL stall_bytes: err %0d want 0", byte_err);
        else n_pass++;
    endtask

    task automatic test_zero();
        run(7'h33, 8'd0, 0, 100, 0);
        n_total++;
        if (addr_q.size() != 0 || first_valid != -1)
            $display("FAIL zero_noaccess: reads %0d valid@%0d want 0 -1", addr_q.size(), first_valid);
        else n_pass++;
        n_total++;
        if (done_cyc != 1 || done_hi != 1 || busy_bad != 0)
            $display("FAIL zero_done: cyc %0d hi %0d busy %0d want 1 1 0", done_cyc, done_hi, busy_bad);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        for (int i = 0; i < 3; i++) mem[7'h40 + i] = $urandom;
        run(7'h40, 8'd3, 5, 70, 0);
        n_total++;
        if (byte_err != 0 || addr_err != 0 || timed_out)
            $display("FAIL ignore_start: byte %0d addr %0d to %0d want 0", byte_err, addr_err, timed_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 8; it++) begin
            logic [6:0] b;
            logic [7:0] c;
            b = 7'($urandom);
            c = 8'($urandom_range(1, 8));
            for (int i = 0; i < int'(c); i++) mem[(int'(b) + i) % 128] = $urandom;
            run(b, c, 0, 60, 0);
            n_total++;
            if (byte_err != 0 || addr_err != 0 || stab_bad != 0 || act_bad != 0 ||
                busy_bad != 0 || done_hi != 1 || timed_out)
                $display("FAIL random_%0d: b %h c %0d byte %0d addr %0d stab %0d busy %0d done %0d want 0s/1",
                         it, b, c, byte_err, addr_err, stab_bad, busy_bad, done_hi);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        run(7'h55, 8'd128, 0, 100, 0);
        n_total++;
        if (addr_err != 0 || byte_err != 0 || timed_out)
            $display("FAIL full_128: addr %0d byte %0d to %0d want 0", addr_err, byte_err, timed_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard;
        for (int i = 0; i < 4; i++) mem[7'h60 + i] = $urandom;
        build_exp(7'h60, 8'd4);
        @(posedge clk); #1;
        base_addr = 7'h60; word_count = 8'd4; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        @(negedge clk);
        while (tx_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[1])
            $display("FAIL rstmid_second: got %h v%b want %h v1", tx_data, tx_valid, exp_q[1]);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({ram_en, ram_addr, tx_data, tx_valid, busy, done} !== 19'd0)
            $display("FAIL rstmid_outputs: got %h want 0",
                     {ram_en, ram_addr, tx_data, tx_valid, busy, done});
        else n_pass++;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem[7'h05] = $urandom;
        run(7'h05, 8'd1, 0, 100, 0);
        n_total++;
        if (byte_err != 0 || addr_err != 0 || done_cyc != BASIC_DONE)
            $display("FAIL rstmid_rerun: byte %0d addr %0d done %0d want 0 0 %0d",
                     byte_err, addr_err, done_cyc, BASIC_DONE);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
